// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A start pulse in IDLE captures bin_in. WIDTH cycles later a one-cycle done
// pulse marks fresh bcd_out/overflow values. Outputs hold between conversions.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_bin_sr;
  logic [WIDTH-1:0]   w_bin_sr_nxt;
  logic [BCD_W-1:0]   r_scr;
  logic [BCD_W-1:0]   w_scr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_ovf_acc;
  logic               w_ovf_acc_nxt;
  logic [BCD_W-1:0]   r_bcd_out;
  logic [BCD_W-1:0]   w_bcd_out_nxt;
  logic               r_overflow;
  logic               w_overflow_nxt;
  logic               r_done;
  logic               w_done_nxt;

  logic [BCD_W-1:0]   w_scr_adj;
  logic [BCD_W-1:0]   w_scr_shift;
  logic               w_ovf_bit;

  // One double-dabble step: add 3 to every digit >= 5, then shift one bit in.
  always_comb begin
    // NOTE: give every combinational output a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_scr_adj = r_scr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scr[4*d +: 4] >= 4'd5) begin
        w_scr_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
      end
    end
    // The bit leaving the top digit means the value needs more digits than we have.
    {w_ovf_bit, w_scr_shift} = {w_scr_adj, r_bin_sr[WIDTH-1]};
  end

  // Next-state and next-register logic for the IDLE/CONVERT controller.
  always_comb begin
    w_state_nxt    = r_state;
    w_bin_sr_nxt   = r_bin_sr;
    w_scr_nxt      = r_scr;
    w_cnt_nxt      = r_cnt;
    w_ovf_acc_nxt  = r_ovf_acc;
    w_bcd_out_nxt  = r_bcd_out;
    w_overflow_nxt = r_overflow;
    w_done_nxt     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_bin_sr_nxt  = bin_in;
          w_scr_nxt     = '0;
          w_ovf_acc_nxt = 1'b0;
          w_cnt_nxt     = CNT_W'(WIDTH);
          w_state_nxt   = CONVERT;
        end
      end
      CONVERT: begin
        w_bin_sr_nxt  = r_bin_sr << 1;
        w_scr_nxt     = w_scr_shift;
        w_ovf_acc_nxt = r_ovf_acc | w_ovf_bit;
        w_cnt_nxt     = r_cnt - CNT_W'(1);
        // Last bit: publish the result directly from this step's shifted value.
        if (r_cnt == CNT_W'(1)) begin
          w_bcd_out_nxt  = w_scr_shift;
          w_overflow_nxt = r_ovf_acc | w_ovf_bit;
          w_done_nxt     = 1'b1;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset that aborts any conversion in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state    <= IDLE;
      r_bin_sr   <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_acc  <= 1'b0;
      r_bcd_out  <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bin_sr   <= w_bin_sr_nxt;
      r_scr      <= w_scr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf_acc  <= w_ovf_acc_nxt;
      r_bcd_out  <= w_bcd_out_nxt;
      r_overflow <= w_overflow_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign busy     = (r_state == CONVERT);
  assign done     = r_done;
  assign bcd_out  = r_bcd_out;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a default 3-digit instance and a
// 2-digit instance that exercises the overflow flag.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic        overflow;

  logic        start2;
  logic [7:0]  bin_in2;
  logic        busy2;
  logic        done2;
  logic [7:0]  bcd_out2;
  logic        overflow2;

  int checks = 0;
  int errors = 0;
  int n;
  int done_cnt;

  always #10 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bin_in(bin_in2),
    .busy(busy2), .done(done2), .bcd_out(bcd_out2), .overflow(overflow2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start on the 3-digit instance and wait (bounded) for done.
  task automatic run_conv(input logic [7:0] val, input logic [11:0] exp_bcd, input string tag);
    int k;
    @(negedge clk);
    start  = 1'b1;
    bin_in = val;
    @(negedge clk);
    start  = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 16'(k), 16'd8);
    check({tag, "_bcd"}, 16'(bcd_out), 16'(exp_bcd));
    check({tag, "_ovf"}, 16'(overflow), 16'd0);
  endtask

  // Same for the 2-digit instance, which also checks the overflow flag.
  task automatic run_conv2(input logic [7:0] val, input logic [7:0] exp_bcd,
                           input logic exp_ovf, input string tag);
    int k;
    @(negedge clk);
    start2  = 1'b1;
    bin_in2 = val;
    @(negedge clk);
    start2  = 1'b0;
    k = 0;
    while (!done2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 16'(k), 16'd8);
    check({tag, "_bcd"}, 16'(bcd_out2), 16'(exp_bcd));
    check({tag, "_ovf"}, 16'(overflow2), 16'(exp_ovf));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    bin_in  = '0;
    start2  = 1'b0;
    bin_in2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_bcd",  16'(bcd_out), 16'd0);
    check("rst_ovf",  16'(overflow), 16'd0);

    // 255: busy for exactly 8 cycles, then a single done pulse.
    start  = 1'b1;
    bin_in = 8'd255;
    @(negedge clk);
    start  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b255_busy%0d", i), 16'({busy, done}), 16'b10);
      @(negedge clk);
    end
    check("b255_done",  16'({busy, done}), 16'b01);
    check("b255_bcd",   16'(bcd_out), 16'h255);
    check("b255_ovf",   16'(overflow), 16'd0);
    @(negedge clk);
    check("b255_done_low", 16'(done), 16'd0);
    check("b255_hold",     16'(bcd_out), 16'h255);

    // Boundary values.
    run_conv(8'd0,   12'h000, "v0");
    run_conv(8'd9,   12'h009, "v9");
    run_conv(8'd10,  12'h010, "v10");
    run_conv(8'd99,  12'h099, "v99");
    run_conv(8'd100, 12'h100, "v100");
    run_conv(8'd128, 12'h128, "v128");

    // Back-to-back with start held: 37 accepted at k, 200 at k+9.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd37;
    @(negedge clk);
    bin_in = 8'd200;
    for (n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n == 9) start = 1'b0;
      check($sformatf("b2b_done%0d", n), 16'(done), 16'((n == 8) || (n == 17)));
      if (n == 8)  check("b2b_bcd37",  16'(bcd_out), 16'h037);
      if (n == 17) check("b2b_bcd200", 16'(bcd_out), 16'h200);
    end

    // Start pulsed mid-conversion with a new operand: must be ignored.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd42;
    @(negedge clk);
    start  = 1'b0;
    done_cnt = 0;
    for (n = 1; n <= 18; n++) begin
      if (n == 3) begin
        start  = 1'b1;
        bin_in = 8'd99;
      end
      @(negedge clk);
      if (n == 3) start = 1'b0;
      if (done) begin
        done_cnt++;
        check("mid_lat", 16'(n), 16'd8);
        check("mid_bcd", 16'(bcd_out), 16'h042);
      end
    end
    check("mid_done_cnt", 16'(done_cnt), 16'd1);

    // Reset aborts a conversion of 255 that follows a completed 17.
    run_conv(8'd17, 12'h017, "v17");
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd255;
    @(negedge clk);
    start  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_bcd",  16'(bcd_out), 16'd0);
    check("abort_ovf",  16'(overflow), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 16'(done_cnt), 16'd0);

    // Reset and start on the same edge: reset wins.
    start  = 1'b1;
    bin_in = 8'd5;
    reset  = 1'b1;
    @(negedge clk);
    check("rst_vs_start_busy", 16'(busy), 16'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_vs_start_idle", 16'(busy), 16'd0);

    // Two-digit instance: overflow and recovery.
    run_conv2(8'd100, 8'h00, 1'b1, "d2_100");
    run_conv2(8'd99,  8'h99, 1'b0, "d2_99");
    run_conv2(8'd255, 8'h55, 1'b1, "d2_255");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
